// File: rtl/tx_frame_reader_if.sv
// FIFO read port and MAC transmit stream as seen by the frame reader.
// master = reader side, slave = FIFO/MAC side.
interface tx_frame_reader_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_read;
   logic [DATA_WIDTH-1:0] tx_mac_data;
   logic                  tx_mac_valid;
   logic                  tx_mac_last;
   logic                  tx_mac_ready;

   modport master (
      input  fifo_empty, fifo_data, tx_mac_ready,
      output fifo_read, tx_mac_data, tx_mac_valid, tx_mac_last
   );

   modport slave (
      output fifo_empty, fifo_data, tx_mac_ready,
      input  fifo_read, tx_mac_data, tx_mac_valid, tx_mac_last
   );
endinterface

// File: rtl/tx_frame_reader.sv
// Pulls queued frames out of the byte FIFO and streams them to the TX MAC,
// with a 2-entry skid buffer and a programmable inter-frame gap.
module tx_frame_reader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 11,
   parameter int unsigned LEN_DEPTH  = 8,
   parameter int unsigned IFG_CYCLES = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [LEN_WIDTH-1:0] frame_len_in,
   input  logic                 frame_len_valid,
   tx_frame_reader_if.master    bus,
   output logic                 len_full,
   output logic                 len_drop,
   output logic                 underrun,
   output logic                 busy,
   output logic [15:0]          tx_frame_cnt
);
   localparam int unsigned PTR_W = $clog2(LEN_DEPTH);
   localparam int unsigned QP_W  = PTR_W + 1;
   localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  rem_rd_q, rem_rd_d;
   logic [LEN_WIDTH-1:0]  rem_tx_q, rem_tx_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;

   logic [LEN_WIDTH-1:0]  lq_mem_q [LEN_DEPTH];
   logic [QP_W-1:0]       lq_wr_q, lq_rd_q;
   logic                  lq_empty_c, lq_full_c, lq_push_c, lq_pop_c;
   logic [LEN_WIDTH-1:0]  lq_head_c;

   logic [DATA_WIDTH-1:0] buf_mem_q [2];
   logic                  buf_wr_q, buf_rd_q;
   logic [1:0]            buf_cnt_q;
   logic                  inflight_q;

   logic                  len_drop_q, under_cond_q, underrun_q;
   logic                  rd_c, valid_c, accept_c, under_cond_c;
   logic [2:0]            occ_c;

   // Length queue status; the extra pointer bit separates full from empty
   assign lq_empty_c = (lq_wr_q == lq_rd_q);
   assign lq_full_c  = (lq_wr_q[PTR_W] != lq_rd_q[PTR_W]) &&
                       (lq_wr_q[PTR_W-1:0] == lq_rd_q[PTR_W-1:0]);
   assign lq_head_c  = lq_mem_q[lq_rd_q[PTR_W-1:0]];
   assign lq_push_c  = frame_len_valid && !lq_full_c && (frame_len_in != '0);

   // Occupancy after this cycle's accept decides whether another read fits
   assign valid_c      = (state_q == SEND) && (buf_cnt_q != 2'd0);
   assign accept_c     = valid_c && bus.tx_mac_ready;
   assign occ_c        = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(accept_c);
   assign under_cond_c = (state_q == SEND) && (rem_rd_q != '0) && (buf_cnt_q == 2'd0) &&
                         !inflight_q && bus.fifo_empty;

   always_comb begin
      state_d     = state_q;
      rem_rd_d    = rem_rd_q;
      rem_tx_d    = rem_tx_q;
      gap_d       = gap_q;
      frame_cnt_d = frame_cnt_q;
      lq_pop_c    = 1'b0;
      rd_c        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!lq_empty_c) begin
               lq_pop_c = 1'b1;
               rem_rd_d = lq_head_c;
               rem_tx_d = lq_head_c;
               state_d  = SEND;
            end
         end
         SEND: begin
            rd_c = (rem_rd_q != '0) && !bus.fifo_empty && (occ_c < 3'd2);
            if (rd_c) begin
               rem_rd_d = rem_rd_q - LEN_WIDTH'(1);
            end
            if (accept_c) begin
               rem_tx_d = rem_tx_q - LEN_WIDTH'(1);
               if (rem_tx_q == LEN_WIDTH'(1)) begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
                  if (IFG_CYCLES == 0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = GAP;
                     gap_d   = GAP_W'(IFG_CYCLES);
                  end
               end
            end
         end
         GAP: begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q <= GAP_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rem_rd_q     <= '0;
         rem_tx_q     <= '0;
         gap_q        <= '0;
         frame_cnt_q  <= '0;
         lq_wr_q      <= '0;
         lq_rd_q      <= '0;
         len_drop_q   <= 1'b0;
         under_cond_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_rd_q     <= rem_rd_d;
         rem_tx_q     <= rem_tx_d;
         gap_q        <= gap_d;
         frame_cnt_q  <= frame_cnt_d;
         if (lq_push_c) lq_wr_q <= lq_wr_q + QP_W'(1);
         if (lq_pop_c)  lq_rd_q <= lq_rd_q + QP_W'(1);
         len_drop_q   <= frame_len_valid && !lq_push_c;
         under_cond_q <= under_cond_c;
         underrun_q   <= under_cond_c && !under_cond_q;
      end
   end

   always_ff @(posedge clk) begin
      if (lq_push_c) begin
         lq_mem_q[lq_wr_q[PTR_W-1:0]] <= frame_len_in;
      end
   end

   // Skid buffer: FIFO data lands one cycle after the read strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_mem_q[0] <= '0;
         buf_mem_q[1] <= '0;
         buf_wr_q     <= 1'b0;
         buf_rd_q     <= 1'b0;
         buf_cnt_q    <= 2'd0;
         inflight_q   <= 1'b0;
      end else begin
         inflight_q <= rd_c;
         if (inflight_q) begin
            buf_mem_q[buf_wr_q] <= bus.fifo_data;
            buf_wr_q            <= ~buf_wr_q;
         end
         if (accept_c) begin
            buf_rd_q <= ~buf_rd_q;
         end
         buf_cnt_q <= buf_cnt_q + 2'(inflight_q) - 2'(accept_c);
      end
   end

   assign bus.fifo_read    = rd_c;
   assign bus.tx_mac_data  = buf_mem_q[buf_rd_q];
   assign bus.tx_mac_valid = valid_c;
   assign bus.tx_mac_last  = valid_c && (rem_tx_q == LEN_WIDTH'(1));
   assign len_full         = lq_full_c;
   assign len_drop         = len_drop_q;
   assign underrun         = underrun_q;
   assign busy             = (state_q != IDLE);
   assign tx_frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_tx_frame_reader.sv
// Directed and randomized checks of tx_frame_reader against a byte-stream
// model: expected bytes per frame, FIFO model with registered output.
module tb_tx_frame_reader;
   localparam int unsigned DW  = 8;
   localparam int unsigned LW  = 11;
   localparam int unsigned LD  = 8;
   localparam int IFG = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [LW-1:0] frame_len_in = '0;
   logic          frame_len_valid = 1'b0;
   logic          len_full, len_drop, underrun, busy;
   logic [15:0]   tx_frame_cnt;

   tx_frame_reader_if #(.DATA_WIDTH(DW)) bus ();

   tx_frame_reader #(
      .DATA_WIDTH(DW), .LEN_WIDTH(LW), .LEN_DEPTH(LD), .IFG_CYCLES(IFG)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .frame_len_in(frame_len_in), .frame_len_valid(frame_len_valid),
      .bus(bus),
      .len_full(len_full), .len_drop(len_drop), .underrun(underrun),
      .busy(busy), .tx_frame_cnt(tx_frame_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // FIFO model: registered data output, registered empty flag
   logic [7:0] feed_q[$];
   logic [7:0] fifo_q[$];
   logic [7:0] held_q[$];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q.delete();
         bus.fifo_empty <= 1'b1;
         bus.fifo_data  <= '0;
      end else begin
         if (bus.fifo_read && fifo_q.size() != 0) bus.fifo_data <= fifo_q.pop_front();
         while (feed_q.size() != 0) fifo_q.push_back(feed_q.pop_front());
         bus.fifo_empty <= (fifo_q.size() == 0);
      end
   end

   int ready_mode = 0;
   initial begin
      bus.tx_mac_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.tx_mac_ready = 1'b1;
            1:       bus.tx_mac_ready = ~bus.tx_mac_ready;
            default: bus.tx_mac_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Expected stream {last, byte}, and observation counters
   logic [8:0] exp_q[$];
   int acc_bytes = 0, acc_frames = 0, rd_cnt = 0, und_cnt = 0, drop_cnt = 0;
   int first_rd_cyc = -1, last_rd_cyc = -1, first_val_cyc = -1, last_acc_cyc = 0, gap_obs = 0;
   bit hold_pend = 0, in_frame = 0;
   logic [8:0] hold_val, e;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 0;
         in_frame  = 0;
      end else begin
         if (bus.fifo_read) begin
            chk("read_nonempty", 32'(bus.fifo_empty), 32'(0));
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
         end
         if (underrun) und_cnt++;
         if (len_drop) drop_cnt++;
         if (hold_pend) begin
            chk("hold_valid", 32'(bus.tx_mac_valid), 32'(1));
            chk("hold_word", 32'({bus.tx_mac_last, bus.tx_mac_data}), 32'(hold_val));
         end
         hold_pend = 0;
         if (bus.tx_mac_valid) begin
            if (!in_frame) begin
               in_frame = 1;
               if (first_val_cyc < 0) first_val_cyc = cyc;
               if (acc_frames > 0) begin
                  gap_obs = cyc - last_acc_cyc;
                  chk("gap_min", 32'(gap_obs >= IFG + 4), 32'(1));
               end
            end
            if (bus.tx_mac_ready) begin
               chk("byte_expected", 32'(exp_q.size() != 0), 32'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("tx_word", 32'({bus.tx_mac_last, bus.tx_mac_data}), 32'(e));
               end
               acc_bytes++;
               if (bus.tx_mac_last) begin
                  acc_frames++;
                  last_acc_cyc = cyc;
                  in_frame = 0;
               end
            end else begin
               hold_pend = 1;
               hold_val  = {bus.tx_mac_last, bus.tx_mac_data};
            end
         end
      end
   end

   int push_cyc = 0;
   int exp_frames = 0;

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_len(input int len);
      frame_len_in    = LW'(len);
      frame_len_valid = 1'b1;
      tick(1);
      frame_len_valid = 1'b0;
      push_cyc = cyc;
   endtask

   // Builds one frame into the model; the first nfeed bytes go to the FIFO now
   task automatic make_frame(input int len, input int nfeed, input logic [7:0] base, input bit rnd);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         b = rnd ? 8'($urandom) : base + 8'(i);
         exp_q.push_back({(i == len - 1), b});
         if (i < nfeed) feed_q.push_back(b);
         else           held_q.push_back(b);
      end
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int k = 0;
      while (acc_frames < n && k < budget) begin tick(1); k++; end
      chk(tag, 32'(acc_frames >= n), 32'(1));
   endtask

   task automatic clear_obs();
      rd_cnt = 0; first_rd_cyc = -1; last_rd_cyc = -1; first_val_cyc = -1;
   endtask

   initial begin
      int k, base, total;
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, base, total, len;
      // Reset values
      tick(3);
      chk("rst_fifo_read", 32'(bus.fifo_read), 32'(0));
      chk("rst_data", 32'(bus.tx_mac_data), 32'(0));
      chk("rst_valid", 32'(bus.tx_mac_valid), 32'(0));
      chk("rst_last", 32'(bus.tx_mac_last), 32'(0));
      chk("rst_len_full", 32'(len_full), 32'(0));
      chk("rst_len_drop", 32'(len_drop), 32'(0));
      chk("rst_underrun", 32'(underrun), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_cnt", 32'(tx_frame_cnt), 32'(0));
      rst_n = 1'b1;
      tick(2);

      // Single frame, ready high: latency, throughput, gap
      clear_obs();
      make_frame(4, 4, 8'hA0, 0);
      tick(2);
      push_len(4); exp_frames++;
      wait_frames(1, 100, "t1_done");
      chk("t1_first_read", 32'(first_rd_cyc), 32'(push_cyc + 1));
      chk("t1_first_valid", 32'(first_val_cyc), 32'(push_cyc + 3));
      chk("t1_read_cnt", 32'(rd_cnt), 32'(4));
      chk("t1_read_span", 32'(last_rd_cyc - first_rd_cyc), 32'(3));
      chk("t1_byte_span", 32'(last_acc_cyc - first_val_cyc), 32'(3));
      while (cyc < last_acc_cyc + IFG) tick(1);
      chk("t1_gap_busy", 32'(busy), 32'(1));
      chk("t1_gap_valid", 32'(bus.tx_mac_valid), 32'(0));
      tick(1);
      chk("t1_gap_end_busy", 32'(busy), 32'(0));
      chk("t1_cnt", 32'(tx_frame_cnt), 32'(exp_frames));

      // Same frame with ready toggling
      clear_obs();
      ready_mode = 1;
      make_frame(4, 4, 8'hA0, 0);
      tick(2);
      push_len(4); exp_frames++;
      wait_frames(2, 200, "t2_done");
      chk("t2_read_cnt", 32'(rd_cnt), 32'(4));
      chk("t2_cnt", 32'(tx_frame_cnt), 32'(exp_frames));
      ready_mode = 0;
      tick(IFG + 4);

      // Length queue full / drop while the reader stalls on an empty FIFO
      und_cnt = 0; drop_cnt = 0;
      push_len(2); exp_frames++;
      tick(4);
      chk("t3_stall_underrun", 32'(und_cnt), 32'(1));
      for (int i = 0; i < 8; i++) begin
         push_len(i + 1); exp_frames++;
         if (i == 6) chk("t3_not_full_7", 32'(len_full), 32'(0));
      end
      chk("t3_full_8", 32'(len_full), 32'(1));
      push_len(5);
      tick(2);
      chk("t3_drop_9th", 32'(drop_cnt), 32'(1));
      chk("t3_still_full", 32'(len_full), 32'(1));
      make_frame(2, 2, 8'h00, 1);
      for (int i = 0; i < 8; i++) make_frame(i + 1, i + 1, 8'h00, 1);
      wait_frames(exp_frames, 3000, "t3_drain");
      chk("t3_cnt", 32'(tx_frame_cnt), 32'(exp_frames));
      chk("t3_not_full", 32'(len_full), 32'(0));
      tick(IFG + 4);
      push_len(0);
      tick(3);
      chk("t3_drop_zero", 32'(drop_cnt), 32'(2));
      chk("t3_zero_idle", 32'(busy), 32'(0));

      // Underrun mid-frame, then completion once data arrives
      und_cnt = 0;
      base = acc_bytes;
      make_frame(3, 1, 8'hC0, 0);
      tick(2);
      push_len(3); exp_frames++;
      k = 0;
      while (acc_bytes < base + 1 && k < 50) begin tick(1); k++; end
      tick(10);
      chk("t4_one_byte", 32'(acc_bytes - base), 32'(1));
      chk("t4_underrun", 32'(und_cnt), 32'(1));
      chk("t4_waiting", 32'(busy), 32'(1));
      while (held_q.size() != 0) feed_q.push_back(held_q.pop_front());
      wait_frames(exp_frames, 100, "t4_done");
      chk("t4_underrun_once", 32'(und_cnt), 32'(1));
      chk("t4_cnt", 32'(tx_frame_cnt), 32'(exp_frames));
      tick(IFG + 4);

      // Back-to-back frames: exact gap between them
      make_frame(2, 2, 8'h10, 0);
      make_frame(1, 1, 8'h20, 0);
      tick(2);
      push_len(2); exp_frames++;
      push_len(1); exp_frames++;
      wait_frames(exp_frames, 200, "t5_done");
      chk("t5_gap_exact", 32'(gap_obs), 32'(IFG + 4));
      chk("t5_cnt", 32'(tx_frame_cnt), 32'(exp_frames));
      tick(IFG + 4);

      // Randomized frames, trickled FIFO, random backpressure
      ready_mode = 2;
      clear_obs();
      und_cnt = 0; drop_cnt = 0; total = 0;
      for (int f = 0; f < 12; f++) begin
         len = $urandom_range(1, 24);
         total += len;
         make_frame(len, 0, 8'h00, 1);
         while (held_q.size() != 0) begin
            feed_q.push_back(held_q.pop_front());
            tick($urandom_range(0, 2));
         end
         k = 0;
         while (len_full && k < 5000) begin tick(1); k++; end
         push_len(len); exp_frames++;
      end
      wait_frames(exp_frames, 8000, "t6_done");
      chk("t6_reads", 32'(rd_cnt), 32'(total));
      chk("t6_cnt", 32'(tx_frame_cnt), 32'(exp_frames));
      chk("t6_no_underrun", 32'(und_cnt), 32'(0));
      chk("t6_no_drop", 32'(drop_cnt), 32'(0));
      chk("t6_model_empty", 32'(exp_q.size()), 32'(0));
      ready_mode = 0;
      tick(IFG + 4);

      // Reset mid-frame with a second length still queued
      base = acc_bytes;
      make_frame(10, 10, 8'h40, 0);
      make_frame(5, 5, 8'h60, 0);
      tick(2);
      push_len(10);
      push_len(5);
      k = 0;
      while (acc_bytes < base + 3 && k < 50) begin tick(1); k++; end
      rst_n = 1'b0;
      #1;
      chk("mrst_fifo_read", 32'(bus.fifo_read), 32'(0));
      chk("mrst_valid", 32'(bus.tx_mac_valid), 32'(0));
      chk("mrst_last", 32'(bus.tx_mac_last), 32'(0));
      chk("mrst_data", 32'(bus.tx_mac_data), 32'(0));
      chk("mrst_busy", 32'(busy), 32'(0));
      chk("mrst_cnt", 32'(tx_frame_cnt), 32'(0));
      chk("mrst_underrun", 32'(underrun), 32'(0));
      exp_q.delete(); feed_q.delete(); held_q.delete();
      tick(2);
      rst_n = 1'b1;
      acc_frames = 0; exp_frames = 0;
      tick(5);
      chk("post_rst_idle", 32'(busy), 32'(0));
      chk("post_rst_cnt", 32'(tx_frame_cnt), 32'(0));
      make_frame(3, 3, 8'h70, 0);
      tick(2);
      push_len(3); exp_frames++;
      wait_frames(1, 100, "post_rst_done");
      chk("post_rst_frame_cnt", 32'(tx_frame_cnt), 32'(exp_frames));
      chk("post_rst_model_empty", 32'(exp_q.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
